thermo_serializer: RTL and testbench
====================================

Name: thermo_serializer

Overview:
- Transmit-side counterpart of the per-word ones counter: accepts a ones-count and emits a Width-bit serial frame, one bit per cycle, MSB-first in time.
- The frame contains exactly that many ones as a thermometer code: ones first, zeros after.
- Used to drive serial popcount receivers and to generate known-popcount stimulus.
- Count input uses a valid/ready handshake; serial output uses valid/ready with a last marker.

Parameters:
- Width, 8, frame length in bits and maximum representable count; legal range is Width >= 2.
- CntWidth, 16, width of the count input, matching the ones-counter output width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- cnt_i  input  CntWidth  requested ones-count, unsigned.
- cnt_valid_i  input  1  cnt_i valid.
- cnt_ready_o  output  1  block can accept a count.
- bit_o  output  1  current serial bit.
- bit_valid_o  output  1  bit_o valid.
- bit_ready_i  input  1  downstream accepts bit_o.
- bit_last_o  output  1  current bit is frame position Width-1.
- sat_o  output  1  current frame was clamped (cnt_i > Width).

Behaviour:
- Reset (rst_ni=0, takes effect immediately, independent of clk_i):
  - state=IDLE, bit index=0, stored count=0.
  - bit_o=0, bit_valid_o=0, bit_last_o=0, sat_o=0, cnt_ready_o=1.
- FSM with two states, IDLE and SEND.
  - cnt_ready_o = (state==IDLE).
  - bit_valid_o = (state==SEND).
- IDLE:
  - On a rising edge with cnt_valid_i & cnt_ready_o:
    - store n_eff = min(cnt_i, Width), comparing at full CntWidth with no truncation before the compare;
    - store sat = (cnt_i > Width);
    - set index=0 and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - bit_o = (index < n_eff); bit_last_o = (index == Width-1); sat_o = stored sat.
  - On a rising edge with bit_ready_i: if index == Width-1 go to IDLE, else index increments.
  - With bit_ready_i=0: hold all outputs and state. bit_o, bit_last_o and sat_o must not change while bit_valid_o=1 and bit_ready_i=0.
- Timing:
  - The first bit is valid in the cycle after count acceptance.
  - With bit_ready_i held at 1, a frame occupies Width cycles and cnt_ready_o returns high the cycle after the last beat.
  - Minimum count-to-count spacing is therefore Width+1 cycles; back-to-back frames are not supported.
- Outside SEND: bit_o=0, bit_last_o=0, sat_o=0.
- Boundary cases:
  - cnt_i=0: frame of all zeros.
  - cnt_i=Width: all ones, sat=0.
  - cnt_i=Width+1 up to 2^CntWidth-1: all ones, sat=1.
  - cnt_valid_i asserted during SEND: ignored, no capture; the upstream must hold valid until ready.
  - cnt_i changing during SEND: no effect on the current frame.
- Mid-frame reset: frame is aborted immediately and outputs take reset values. The first count after reset release starts a fresh frame at index 0.
- Invariant: the popcount of every completed frame equals min(cnt_i, Width).
- Index register width is clog2(Width); no wrap beyond Width-1.

Test Plan:
- Reset release, bit_ready_i=1, cnt_i=3 valid for 1 cycle -> next cycle starts frame 1,1,1,0,0,0,0,0; bit_last_o high on 8th beat only; sat_o=0; cnt_ready_o low for 8 cycles, high on the 9th.
- cnt_i=0, then (after ready) cnt_i=8 -> first frame all 0s, second frame all 1s; sat_o=0 for both; each frame's popcount matches the count.
- cnt_i=200 (and separately 16'hFFFF) -> frame of 8 ones; sat_o=1 for all 8 beats.
- cnt_i=5 with bit_ready_i toggling 1,0,0,1,... -> bit sequence still 1,1,1,1,1,0,0,0; outputs stable during every stall; bit_last_o coincides with the final accepted beat.
- cnt_valid_i held high with cnt_i changing during SEND -> only the value present at acceptance is used; the next capture occurs exactly when cnt_ready_o returns high.
- rst_ni pulsed low mid-frame at beat 4 of cnt_i=6 -> bit_valid_o=0 and cnt_ready_o=1 immediately; then cnt_i=2 gives frame 1,1,0,0,0,0,0,0 from index 0.

Source files
------------

// File: rtl/thermo_serializer.sv
// thermo_serializer
// Turns a ones-count into a Width-bit serial thermometer frame, one bit per
// cycle: ones first, zeros after. Counts above Width are clamped to Width and
// flagged on sat_o for the whole frame.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cnt_i        requested ones-count (unsigned, CntWidth bits)
//   cnt_valid_i  cnt_i valid
//   cnt_ready_o  block is idle and can accept a count
//   bit_o        current serial bit
//   bit_valid_o  bit_o valid (frame in progress)
//   bit_ready_i  downstream accepts bit_o
//   bit_last_o   current bit is frame position Width-1
//   sat_o        current frame was clamped (cnt_i > Width)
module thermo_serializer #(
  parameter int unsigned Width    = 8,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CntWidth-1:0] cnt_i,
  input  logic                cnt_valid_i,
  output logic                cnt_ready_o,
  output logic                bit_o,
  output logic                bit_valid_o,
  input  logic                bit_ready_i,
  output logic                bit_last_o,
  output logic                sat_o
);

  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned NW   = $clog2(Width + 1);
  // Saturation compare runs at least 32 bits wide so neither cnt_i nor Width
  // is truncated before the compare.
  localparam int unsigned CmpW = (CntWidth > 32) ? CntWidth : 32;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Width - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [NW-1:0]   n_q;

  logic            cnt_sat;
  logic [NW-1:0]   n_eff;
  logic [IdxW-1:0] idx_nxt;
  logic            bit_nxt;

  always_comb begin
    cnt_sat = CmpW'(cnt_i) > CmpW'(Width);
    n_eff   = cnt_sat ? NW'(Width) : NW'(cnt_i);
    idx_nxt = idx_q + IdxW'(1);
    bit_nxt = NW'(idx_nxt) < n_q;
  end

  // Outputs are registered alongside the state; on a stalled beat nothing is
  // assigned, so every output holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      n_q         <= '0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
      bit_last_o  <= 1'b0;
      sat_o       <= 1'b0;
      cnt_ready_o <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cnt_valid_i) begin
            state_q     <= StSend;
            idx_q       <= '0;
            n_q         <= n_eff;
            bit_o       <= (n_eff != '0);
            bit_valid_o <= 1'b1;
            bit_last_o  <= 1'b0; // Width >= 2, so index 0 is never last
            sat_o       <= cnt_sat;
            cnt_ready_o <= 1'b0;
          end
        end
        StSend: begin
          if (bit_ready_i) begin
            if (idx_q == LastIdx) begin
              state_q     <= StIdle;
              idx_q       <= '0;
              bit_o       <= 1'b0;
              bit_valid_o <= 1'b0;
              bit_last_o  <= 1'b0;
              sat_o       <= 1'b0;
              cnt_ready_o <= 1'b1;
            end else begin
              idx_q      <= idx_nxt;
              bit_o      <= bit_nxt;
              bit_last_o <= (idx_nxt == LastIdx);
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thermo_serializer.sv
// Directed bench for thermo_serializer (Width=8, CntWidth=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_thermo_serializer;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] cnt_i;
  logic        cnt_valid_i;
  logic        cnt_ready_o;
  logic        bit_o;
  logic        bit_valid_o;
  logic        bit_ready_i;
  logic        bit_last_o;
  logic        sat_o;

  int n_tests = 0;
  int n_fail  = 0;

  thermo_serializer #(
    .Width    (8),
    .CntWidth (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cnt_i       (cnt_i),
    .cnt_valid_i (cnt_valid_i),
    .cnt_ready_o (cnt_ready_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .bit_ready_i (bit_ready_i),
    .bit_last_o  (bit_last_o),
    .sat_o       (sat_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one count and walks the whole frame. With stall set, bit_ready_i
  // follows the pattern 1,0,0,1 repeating. With hold set, cnt_valid_i stays
  // high through the frame while cnt_i is switched to next_cnt.
  task automatic run_frame(input logic [15:0] cnt, input int n_exp, input bit sat_exp,
                           input bit stall, input bit hold, input logic [15:0] next_cnt,
                           input string tag);
    int  beat;
    int  cyc;
    int  ones;
    bit  r;
    bit  pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0;
    while (!cnt_ready_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, " ready before send"}, 32'(cnt_ready_o), 32'd1);
    cnt_i       = cnt;
    cnt_valid_i = 1'b1;
    @(negedge clk_i);
    if (hold) cnt_i = next_cnt;
    else cnt_valid_i = 1'b0;
    check({tag, " first beat valid"}, 32'(bit_valid_o), 32'd1);
    beat = 0;
    ones = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 40) begin
      check({tag, " bit"}, 32'(bit_o), 32'(beat < n_exp));
      check({tag, " last"}, 32'(bit_last_o), 32'(beat == 7));
      check({tag, " sat"}, 32'(sat_o), 32'(sat_exp));
      check({tag, " valid"}, 32'(bit_valid_o), 32'd1);
      check({tag, " cnt_ready low"}, 32'(cnt_ready_o), 32'd0);
      r = stall ? pat[cyc % 4] : 1'b1;
      bit_ready_i = r;
      if (r) ones += int'(bit_o);
      @(negedge clk_i);
      if (r) beat++;
      cyc++;
    end
    if (beat < 8) check({tag, " frame timeout"}, 32'(beat), 32'd8);
    bit_ready_i = 1'b1;
    check({tag, " popcount"}, 32'(ones), 32'(n_exp));
    check({tag, " ready after"}, 32'(cnt_ready_o), 32'd1);
    check({tag, " valid after"}, 32'(bit_valid_o), 32'd0);
    check({tag, " bit idle"}, 32'(bit_o), 32'd0);
    check({tag, " sat idle"}, 32'(sat_o), 32'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    cnt_i       = '0;
    cnt_valid_i = 1'b0;
    bit_ready_i = 1'b1;
    #12;
    check("rst ready", 32'(cnt_ready_o), 32'd1);
    check("rst valid", 32'(bit_valid_o), 32'd0);
    check("rst bit", 32'(bit_o), 32'd0);
    check("rst last", 32'(bit_last_o), 32'd0);
    check("rst sat", 32'(sat_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_frame(16'd3, 3, 1'b0, 1'b0, 1'b0, 16'd0, "cnt3");
    run_frame(16'd0, 0, 1'b0, 1'b0, 1'b0, 16'd0, "cnt0");
    run_frame(16'd8, 8, 1'b0, 1'b0, 1'b0, 16'd0, "cnt8");
    run_frame(16'd9, 8, 1'b1, 1'b0, 1'b0, 16'd0, "cnt9");
    run_frame(16'd200, 8, 1'b1, 1'b0, 1'b0, 16'd0, "cnt200");
    run_frame(16'hFFFF, 8, 1'b1, 1'b0, 1'b0, 16'd0, "cntffff");
    run_frame(16'd5, 5, 1'b0, 1'b1, 1'b0, 16'd0, "stall5");
    // Valid held through the frame with cnt_i moved to 4: the frame must use 2,
    // and 4 must be captured on the edge where cnt_ready_o is back high.
    run_frame(16'd2, 2, 1'b0, 1'b0, 1'b1, 16'd4, "hold2");
    run_frame(16'd4, 4, 1'b0, 1'b0, 1'b0, 16'd0, "hold4");

    // Mid-frame reset at beat 4 of a count of 6.
    cnt_i       = 16'd6;
    cnt_valid_i = 1'b1;
    @(negedge clk_i);
    cnt_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst6 bit", 32'(bit_o), 32'd1);
      @(negedge clk_i);
    end
    check("rst6 beat4 valid", 32'(bit_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst valid", 32'(bit_valid_o), 32'd0);
    check("midrst ready", 32'(cnt_ready_o), 32'd1);
    check("midrst bit", 32'(bit_o), 32'd0);
    check("midrst sat", 32'(sat_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_frame(16'd2, 2, 1'b0, 1'b0, 1'b0, 16'd0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
